// File: rtl/stream_mux_pkg.sv
// Shared constants, lock-state type and one-hot helper for the N:1 stream mux.
package stream_mux_pkg;

  localparam logic MODE_RR     = 1'b0;
  localparam logic MODE_FORCED = 1'b1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Supports up to 16 channels; callers zero-extend and truncate as needed.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with round-robin or forced selection and one output register stage.
// Define STREAM_MUX_PKT_LOCK_EN to hold the grant on one channel until its in_last beat.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     in_valid,
  input  logic [N_CH*W-1:0]   in_data,
  input  logic [N_CH-1:0]     in_last,
  output logic [N_CH-1:0]     in_ready,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  output logic                out_last,
  output logic [SEL_W-1:0]    out_ch
);

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q,  out_data_d;
  logic             out_last_q,  out_last_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  logic             slot_free;
  logic [N_CH-1:0]  sel_mask;
  logic [N_CH-1:0]  req;
  logic [N_CH-1:0]  gnt;
  logic [SEL_W-1:0] g_idx;
  logic [W-1:0]     g_data;
  logic             g_last;
  logic             xfer;
  logic             adv;

`ifdef STREAM_MUX_PKT_LOCK_EN
  lock_state_e      lock_q, lock_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic [N_CH-1:0]  lock_mask;
`endif

  assign slot_free = !out_valid_q || out_ready;

  // An out-of-range sel matches no mask bit, so nothing becomes eligible.
  always_comb begin
    sel_mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      sel_mask[i] = (int'(sel) == i);
    end
    req = (mode == MODE_FORCED) ? (in_valid & sel_mask) : in_valid;
`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_mask = '0;
    for (int i = 0; i < N_CH; i++) begin
      lock_mask[i] = (int'(lock_ch_q) == i);
    end
    if (lock_q == LOCKED) req = in_valid & lock_mask;
`endif
  end

  rr_arbiter #(.N(N_CH)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  assign in_ready = rst ? '0 : (gnt & {N_CH{slot_free}});
  assign xfer     = |in_ready;
  assign g_idx    = SEL_W'(onehot_to_idx(16'(gnt)));

  always_comb begin
    g_data = '0;
    g_last = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt[i]) begin
        g_data = in_data[i*W +: W];
        g_last = in_last[i];
      end
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  assign adv = xfer && (mode == MODE_RR) && g_last;
`else
  assign adv = xfer && (mode == MODE_RR);
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = g_data;
      out_last_d  = g_last;
      out_ch_d    = g_idx;
    end else if (slot_free) begin
      out_valid_d = 1'b0;
    end
    if (adv) begin
      ptr_d = (g_idx == SEL_W'(N_CH - 1)) ? '0 : g_idx + 1'b1;
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      lock_d    = g_last ? UNLOCKED : LOCKED;
      lock_ch_d = g_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= UNLOCKED;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule
